// File: rtl/multi_limb_adder_seq_pkg.sv
// Shared definitions for the multi-limb sequential adder: limb width, FSM
// state encoding and the limb-index width helper.
package multi_limb_adder_seq_pkg;

    localparam int LIMB_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    // A single-limb build still needs a 1-bit index register.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/multi_limb_adder_seq_parallel_adder.sv
// 8-bit parallel adder used as the single limb datapath of the sequencer.
// Purely combinational: {cout, sum} = a + b + cin.
module parallel_adder
    import multi_limb_adder_seq_pkg::*;
(
    input  logic [LIMB_W-1:0] a,
    input  logic [LIMB_W-1:0] b,
    input  logic              cin,
    output logic [LIMB_W-1:0] sum,
    output logic              cout
);

    logic [LIMB_W:0] total;

    always_comb begin
        total = {1'b0, a} + {1'b0, b} + {{LIMB_W{1'b0}}, cin};
    end

    assign sum  = total[LIMB_W-1:0];
    assign cout = total[LIMB_W];

endmodule

// File: rtl/multi_limb_adder_seq.sv
// Wide adder that reuses one 8-bit parallel_adder, one limb per clock, LSB first.
// Optional ADDER_OVF_EN adds the ovf port (two's-complement overflow of the full sum).
module multi_limb_adder_seq
    import multi_limb_adder_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WORDS*LIMB_W-1:0]   op_a,
    input  logic [WORDS*LIMB_W-1:0]   op_b,
    input  logic                      cin,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WORDS*LIMB_W-1:0]   result,
`ifdef ADDER_OVF_EN
    output logic                      cout,
    output logic                      ovf
`else
    output logic                      cout
`endif
);

    localparam int IDX_W = idx_width(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_e                          state_q, state_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic                            carry_q, carry_d;
    logic [WORDS-1:0][LIMB_W-1:0]    a_q, a_d;
    logic [WORDS-1:0][LIMB_W-1:0]    b_q, b_d;
    logic [WORDS-1:0][LIMB_W-1:0]    result_q, result_d;
    logic                            cout_q, cout_d;
    logic                            ovf_q, ovf_d;

    logic [LIMB_W-1:0]               add_a, add_b, add_sum;
    logic                            add_cout;
    logic                            msb_carry_in;

    assign add_a = a_q[idx_q];
    assign add_b = b_q[idx_q];

    parallel_adder u_limb_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Carry into the sign bit recovered from the sign-bit sum itself.
    assign msb_carry_in = add_a[LIMB_W-1] ^ add_b[LIMB_W-1] ^ add_sum[LIMB_W-1];

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                result_d[idx_q] = add_sum;
                carry_d         = add_cout;
                idx_d           = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    cout_d  = add_cout;
                    ovf_d   = msb_carry_in ^ add_cout;
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    // in_ready must read 0 for the whole time rst is asserted, not just after an edge.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign cout      = cout_q;

`ifdef ADDER_OVF_EN
    assign ovf = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_multi_limb_adder_seq.sv
// Directed testbench for multi_limb_adder_seq (WORDS=4); ovf checks are active
// when ADDER_OVF_EN is defined.
module tb_multi_limb_adder_seq;

    localparam int WORDS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        cout;
    logic        ovf;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    multi_limb_adder_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
`ifdef ADDER_OVF_EN
        .cout      (cout),
        .ovf       (ovf)
`else
        .cout      (cout)
`endif
    );

`ifndef ADDER_OVF_EN
    assign ovf = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: 0x%0h", tag, got);
        end
    endtask

    // One full operation: offer operands, wait for result, optionally stall in DONE.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic c, input logic [31:0] exp_r, input logic exp_c,
                          input logic exp_v, input int stall);
        int lat;
        @(negedge clk);
        check({tag, ".in_ready"}, in_ready, 1);
        op_a = a; op_b = b; cin = c; in_valid = 1'b1; out_ready = (stall == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        op_a = ~a; op_b = ~b; cin = ~c;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, lat, WORDS);
        check({tag, ".result"}, result, exp_r);
        check({tag, ".cout"}, cout, exp_c);
`ifdef ADDER_OVF_EN
        check({tag, ".ovf"}, ovf, exp_v);
`endif
        if (stall > 0) begin
            for (int i = 0; i < stall; i++) begin
                in_valid = 1'b1; op_a = 32'h11111111; op_b = 32'h22222222;
                @(posedge clk); #1;
                check({tag, ".stall_result"}, result, exp_r);
                check({tag, ".stall_cout"}, cout, exp_c);
                check({tag, ".stall_valid"}, out_valid, 1);
                check({tag, ".stall_in_ready"}, in_ready, 0);
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check({tag, ".valid_drop"}, out_valid, 0);
        check({tag, ".ready_back"}, in_ready, 1);
    endtask

    initial begin
        #1;
        check("reset.in_ready", in_ready, 0);
        check("reset.out_valid", out_valid, 0);
        check("reset.result", result, 0);
        check("reset.cout", cout, 0);
        check("reset.ovf", ovf, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op("basic",    32'h0000000A, 32'h00000005, 1'b0, 32'h0000000F, 1'b0, 1'b0, 0);
        run_op("ripple",   32'h00FFFFFF, 32'h00000001, 1'b0, 32'h01000000, 1'b0, 1'b0, 0);
        run_op("cin",      32'h00000064, 32'h00000032, 1'b1, 32'h00000097, 1'b0, 1'b0, 0);
        run_op("wrap",     32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 0);
        run_op("limbcar",  32'h80808080, 32'h80808080, 1'b0, 32'h01010100, 1'b1, 1'b1, 0);
        run_op("stall",    32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1, 32'h00000000, 1'b1, 1'b0, 5);
        run_op("after",    32'hDEADBEEF, 32'h01234567, 1'b0, 32'hDFD10456, 1'b0, 1'b0, 0);

        // Abort an operation two edges after capture.
        @(negedge clk);
        op_a = 32'h12345678; op_b = 32'h11111111; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort.out_valid", out_valid, 0);
        check("abort.result", result, 0);
        check("abort.cout", cout, 0);
        check("abort.in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        run_op("postrst",  32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0, 0);

        run_op("ovf_pos",  32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 0);
        run_op("ovf_neg",  32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 0);
        run_op("ovf_none", 32'h00000001, 32'hFFFFFFFF, 1'b0, 32'h00000000, 1'b1, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
